// File: rtl/gp_pkg.sv
// gp_pkg: shared state encoding, block/key widths and watchdog default for the grasspopper arbiter
package gp_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_ARM, ST_RUN, ST_RESP} gp_state_t;
  localparam int GP_BLOCK_W = 128;
  localparam int GP_KEY_W = 256;
  localparam int GP_TIMEOUT = 64;
endpackage

// File: rtl/gp_rr_pick.sv
// gp_rr_pick: combinational round-robin selector, first set request at or after rr_ptr
module gp_rr_pick
  import gp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic            any,
  output logic [PW-1:0]   grant
);
  logic [PW-1:0] idx;
  // scan from the farthest candidate back so the nearest one to rr_ptr wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (req[idx]) grant = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/gp_arbiter.sv
// gp_arbiter: round-robin sharing of one iterative grasspopper core between NREQ requesters
module gp_arbiter
  import gp_pkg::*;
#(
  parameter int DATA_W = GP_BLOCK_W,
  parameter int NREQ = 2,
  parameter int TIMEOUT = GP_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   resp_err,
  output logic                   core_start,
  output logic [DATA_W-1:0]      core_data_o,
  input  logic [DATA_W-1:0]      core_data_i,
  input  logic                   core_busy,
  output logic                   busy
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  gp_state_t state, nxt;
  logic [PW-1:0] rr_ptr, grant, pick;
  logic pick_any, wdog_exp;
  logic [WW-1:0] wdog;
  gp_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .any(pick_any),
    .grant(pick)
  );
  assign wdog_exp = wdog == WW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  nxt = pick_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: nxt = ST_ARM;
      ST_ARM:   nxt = ST_RUN;
      ST_RUN:   nxt = (!core_busy || wdog_exp) ? ST_RESP : ST_RUN;
      ST_RESP:  nxt = resp_ready[grant] ? ST_IDLE : ST_RESP;
      default:  nxt = ST_IDLE;
    endcase
  end
  // req_ready is gated by reset so an asserted reset silences the bus at once
  always_comb begin
    req_ready = (reset && state == ST_IDLE && pick_any) ? NREQ'(1) << pick : '0;
    resp_valid = (state == ST_RESP) ? NREQ'(1) << grant : '0;
    core_start = state == ST_ISSUE;
    busy = state != ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      grant <= '0;
      wdog <= '0;
      core_data_o <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && pick_any) begin
        grant <= pick;
        core_data_o <= req_data[pick*DATA_W +: DATA_W];
      end
      if (state == ST_ARM) wdog <= '0;
      if (state == ST_RUN) begin
        if (!core_busy) begin
          resp_data <= core_data_i;
          resp_err <= 1'b0;
        end else if (wdog_exp) begin
          resp_data <= '0;
          resp_err <= 1'b1;
        end else wdog <= wdog + 1'b1;
      end
      if (state == ST_RESP && resp_ready[grant])
        rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end
endmodule

// File: tb/tb_gp_arbiter.sv
// tb_gp_arbiter: scoreboard bench for gp_arbiter with a behavioural grasspopper core model
module tb_gp_arbiter;
  localparam int N = 3;
  localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] MASK = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  typedef struct {int id; logic [127:0] data; logic err;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*128-1:0] req_data = '0;
  logic [N-1:0] resp_valid;
  logic [N-1:0] resp_ready = '1;
  logic [127:0] resp_data, core_data_o, core_data_i, core_out;
  logic resp_err, core_start, core_busy, busy;
  bit hang = 0;
  int busy_len = 0;
  int cnt = 0;
  int errs = 0;
  int checks = 0;
  logic [127:0] blk [N][8];
  int idx [N] = '{0, 0, 0};
  int n [N] = '{0, 0, 0};
  exp_t exp_q[$];
  exp_t e;
  logic [N-1:0] hs;

  gp_arbiter #(.DATA_W(128), .NREQ(N), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .core_start(core_start), .core_data_o(core_data_o), .core_data_i(core_data_i),
    .core_busy(core_busy), .busy(busy)
  );

  always #5 clk = ~clk;

  // core model: the GOST test vector encrypts to its known ciphertext, anything else is XOR-masked
  always @(posedge clk) begin
    if (core_start) begin
      core_out <= (core_data_o == PT) ? CT : core_data_o ^ MASK;
      cnt <= busy_len;
    end else if (cnt > 0) cnt <= cnt - 1;
  end
  assign core_busy = hang || cnt > 0;
  assign core_data_i = core_out;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input int i, input logic [127:0] d);
    blk[i][n[i]] = d;
    n[i]++;
  endtask

  task automatic expect_resp(input int id, input logic [127:0] d, input logic err);
    exp_q.push_back('{id, d, err});
  endtask

  task automatic wait_ready(input int i);
    bit found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      tick();
      found = req_ready[i];
    end
    if (!found) chk("wait_req_ready", 128'(0), 128'(1));
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) tick();
    if (exp_q.size() != 0) begin
      chk("drain_pending", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    chk({tag, "_resp_data"}, resp_data, 128'(0));
    chk({tag, "_resp_err"}, 128'(resp_err), 128'(0));
    chk({tag, "_core_start"}, 128'(core_start), 128'(0));
    chk({tag, "_core_data_o"}, core_data_o, 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  // requester driver: inputs change just after the rising edge, advancing on accepted handshakes
  initial forever begin
    @(negedge clk);
    hs = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) idx[i]++;
      req_valid[i] = idx[i] < n[i];
      req_data[i*128 +: 128] = (idx[i] < n[i]) ? blk[i][idx[i]] : '0;
    end
  end

  // monitor: every completed response handshake is matched against the next expectation
  always @(negedge clk) begin
    if (reset && (resp_valid & resp_ready) != '0) begin
      if (exp_q.size() == 0) chk("resp_unexpected", 128'(resp_valid), 128'(0));
      else begin
        e = exp_q.pop_front();
        chk("resp_grant", 128'(resp_valid), 128'(3'b001 << e.id));
        chk("resp_data", resp_data, e.data);
        chk("resp_err", 128'(resp_err), 128'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit stable;
    int t;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();
    // single request: GOST vector, minimum latency
    busy_len = 0;
    offer(0, PT);
    expect_resp(0, CT, 1'b0);
    wait_ready(0);
    chk("t1_req_ready", 128'(req_ready), 128'(3'b001));
    chk("t1_busy_idle", 128'(busy), 128'(0));
    tick();
    chk("t1_core_start", 128'(core_start), 128'(1));
    chk("t1_core_data_o", core_data_o, PT);
    chk("t1_no_ready", 128'(req_ready), 128'(0));
    tick();
    chk("t1_start_pulse", 128'(core_start), 128'(0));
    tick();
    tick();
    chk("t1_resp_valid", 128'(resp_valid), 128'(3'b001));
    drain();
    // lines 2 and 0 with rr_ptr=1: grant 2 then 0
    busy_len = 2;
    offer(0, 128'h00000000_11111111_22222222_33333333);
    offer(2, 128'h44444444_55555555_66666666_77777777);
    expect_resp(2, 128'h44444444_55555555_66666666_77777777 ^ MASK, 1'b0);
    expect_resp(0, 128'h00000000_11111111_22222222_33333333 ^ MASK, 1'b0);
    drain();
    // response backpressure on line 1 while line 0 waits
    @(posedge clk);
    #1 resp_ready = 3'b101;
    offer(1, 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3);
    expect_resp(1, 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3 ^ MASK, 1'b0);
    wait_ready(1);
    offer(0, 128'hd0d0d0d0_d1d1d1d1_d2d2d2d2_d3d3d3d3);
    expect_resp(0, 128'hd0d0d0d0_d1d1d1d1_d2d2d2d2_d3d3d3d3 ^ MASK, 1'b0);
    for (t = 0; t < 100 && !resp_valid[1]; t++) tick();
    chk("bp_resp_valid", 128'(resp_valid), 128'(3'b010));
    stable = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (resp_valid != 3'b010 || resp_err !== 1'b0 || req_ready != '0 ||
          resp_data !== (128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3 ^ MASK)) stable = 0;
    end
    chk("bp_stable", 128'(stable), 128'(1));
    @(posedge clk);
    #1 resp_ready = 3'b111;
    tick();
    tick();
    chk("bp_idle_busy", 128'(busy), 128'(0));
    chk("bp_idle_resp_valid", 128'(resp_valid), 128'(0));
    chk("bp_next_grant", 128'(req_ready), 128'(3'b001));
    drain();
    // watchdog: core never finishes
    hang = 1;
    offer(2, 128'hee00ee00_ee00ee00_ee00ee00_ee00ee00);
    expect_resp(2, 128'(0), 1'b1);
    wait_ready(2);
    for (t = 0; t < 200 && resp_valid == '0; t++) tick();
    chk("wdog_latency", 128'(t), 128'(67));
    chk("wdog_err", 128'(resp_err), 128'(1));
    drain();
    hang = 0;
    // contention on lines 0 and 1 from rr_ptr=0: grants 0,1,0,1
    busy_len = 1;
    offer(0, 128'haaaa0001_aaaa0001_aaaa0001_aaaa0001);
    offer(1, 128'hbbbb0001_bbbb0001_bbbb0001_bbbb0001);
    offer(0, 128'haaaa0002_aaaa0002_aaaa0002_aaaa0002);
    offer(1, 128'hbbbb0002_bbbb0002_bbbb0002_bbbb0002);
    expect_resp(0, 128'haaaa0001_aaaa0001_aaaa0001_aaaa0001 ^ MASK, 1'b0);
    expect_resp(1, 128'hbbbb0001_bbbb0001_bbbb0001_bbbb0001 ^ MASK, 1'b0);
    expect_resp(0, 128'haaaa0002_aaaa0002_aaaa0002_aaaa0002 ^ MASK, 1'b0);
    expect_resp(1, 128'hbbbb0002_bbbb0002_bbbb0002_bbbb0002 ^ MASK, 1'b0);
    drain();
    // async reset during RUN, then rr_ptr must restart at 0
    busy_len = 10;
    offer(0, 128'hf0f0f0f0_f0f0f0f0_f0f0f0f0_f0f0f0f0);
    wait_ready(0);
    repeat (4) tick();
    chk("rst_pre_busy", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1 chk_all_zero("midrst");
    tick();
    tick();
    reset = 1'b1;
    busy_len = 1;
    offer(1, 128'h99990001_99990001_99990001_99990001);
    offer(2, 128'h88880002_88880002_88880002_88880002);
    expect_resp(1, 128'h99990001_99990001_99990001_99990001 ^ MASK, 1'b0);
    expect_resp(2, 128'h88880002_88880002_88880002_88880002 ^ MASK, 1'b0);
    drain();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
